mem_loader: RTL

Boot-time memory preloader and port arbiter between an external load stream and the CPU core. It owns the single memory port while the core is held in reset, writes an arbitrary address/data stream into memory, and optionally verifies the load by readback checksum. It then releases the core and passes core memory traffic straight through. It replaces the testbench-side `manual_mem` muxing on `addr`, `din` and `we` with synthesizable logic.

---
 rtl/mem_loader.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/mem_loader.sv
// Boot-time memory preloader and core/loader port arbiter.
// Define MEM_LOADER_VERIFY_EN to add checksum readback verification.
module mem_loader #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 32,
  parameter int CW         = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_last,
  input  logic [ADDR_WIDTH-1:0] core_addr,
  input  logic [DATA_WIDTH-1:0] core_din,
  input  logic                  core_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  output logic                  core_reset_n,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [CW-1:0]         word_count
`ifdef MEM_LOADER_VERIFY_EN
  ,
  output logic [DATA_WIDTH-1:0] checksum
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
`ifdef MEM_LOADER_VERIFY_EN
    S_VERIFY,
`endif
    S_RUN,
    S_ERROR
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LIMIT = ADDR_WIDTH'(DEPTH);

  state_t        state;
  logic          fire;
  logic          legal;
  logic          clr;
  logic [CW-1:0] cnt_n;

  assign legal = load_addr < LIMIT;
  assign fire  = (state == S_LOAD) && load_valid;
  assign clr   = (state == S_IDLE) ||
                 ((state == S_ERROR) && start);
  assign cnt_n = (word_count == '1) ? word_count
                                    : word_count + CW'(1);

  assign load_ready   = state == S_LOAD;
  assign core_reset_n = state == S_RUN;
  assign done         = state == S_RUN;
  assign error        = state == S_ERROR;

`ifdef MEM_LOADER_VERIFY_EN
  logic [DATA_WIDTH-1:0] sum;
  logic [DATA_WIDTH-1:0] acc;
  logic [DATA_WIDTH-1:0] acc_n;
  logic [ADDR_WIDTH-1:0] lo;
  logic [ADDR_WIDTH-1:0] hi;
  logic [ADDR_WIDTH-1:0] lo_n;
  logic [ADDR_WIDTH-1:0] hi_n;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_pend;
  logic                  rd_done;

  assign busy     = (state == S_LOAD) || (state == S_VERIFY);
  assign checksum = sum;
  assign acc_n    = acc + mem_dout;
  assign lo_n     = (load_addr < lo) ? load_addr : lo;
  assign hi_n     = (load_addr > hi) ? load_addr : hi;
`else
  logic unused_dout;

  assign busy        = state == S_LOAD;
  assign unused_dout = ^mem_dout;
`endif

  always_comb begin
    mem_addr = '0;
    mem_din  = '0;
    mem_we   = 1'b0;
    case (state)
      S_LOAD: begin
        if (fire) begin
          mem_addr = load_addr;
          mem_din  = load_data;
          mem_we   = legal;
        end
      end
`ifdef MEM_LOADER_VERIFY_EN
      S_VERIFY: mem_addr = rd_addr;
`endif
      S_RUN: begin
        mem_addr = core_addr;
        mem_din  = core_din;
        mem_we   = core_we;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      word_count <= '0;
`ifdef MEM_LOADER_VERIFY_EN
      sum     <= '0;
      acc     <= '0;
      lo      <= '1;
      hi      <= '0;
      rd_addr <= '0;
      rd_pend <= 1'b0;
      rd_done <= 1'b0;
`endif
    end else begin
      if (clr) begin
        word_count <= '0;
`ifdef MEM_LOADER_VERIFY_EN
        sum <= '0;
        lo  <= '1;
        hi  <= '0;
`endif
      end
      case (state)
        S_IDLE: if (start) state <= S_LOAD;
        S_LOAD: begin
          if (fire) begin
            if (!legal) begin
              state <= S_ERROR;
            end else begin
              word_count <= cnt_n;
`ifdef MEM_LOADER_VERIFY_EN
              sum <= sum + load_data;
              lo  <= lo_n;
              hi  <= hi_n;
              if (load_last) begin
                state   <= S_VERIFY;
                rd_addr <= lo_n;
                rd_pend <= 1'b0;
                rd_done <= 1'b0;
                acc     <= '0;
              end
`else
              if (load_last) state <= S_RUN;
`endif
            end
          end
        end
`ifdef MEM_LOADER_VERIFY_EN
        // Read data trails the address by one cycle.
        S_VERIFY: begin
          rd_pend <= !rd_done;
          if (rd_pend) acc <= acc_n;
          if (!rd_done) begin
            if (rd_addr == hi) rd_done <= 1'b1;
            else rd_addr <= rd_addr + ADDR_WIDTH'(1);
          end
          if (rd_done && rd_pend)
            state <= (acc_n == sum) ? S_RUN : S_ERROR;
        end
`endif
        S_ERROR: if (start) state <= S_LOAD;
        default: ;
      endcase
    end
  end

endmodule
